// File: rtl/ase_cfg_fifo_if.sv
// Handshake/status bundle for ase_cfg_fifo: producer/consumer side is master, FIFO is slave.
interface ase_cfg_fifo_if #(
  parameter int DATA_WIDTH  = 64,
  parameter int DEPTH_BASE2 = 3
);
  logic                   flush;
  logic                   wr_en;
  logic [DATA_WIDTH-1:0]  data_in;
  logic                   rd_en;
  logic [DATA_WIDTH-1:0]  data_out;
  logic                   data_out_v;
  logic                   full;
  logic                   alm_full;
  logic                   empty;
  logic                   alm_empty;
  logic [DEPTH_BASE2:0]   count;
  logic                   overflow;
  logic                   underflow;

  modport master (
    output flush, wr_en, data_in, rd_en,
    input  data_out, data_out_v, full, alm_full, empty, alm_empty, count, overflow, underflow
  );

  modport slave (
    input  flush, wr_en, data_in, rd_en,
    output data_out, data_out_v, full, alm_full, empty, alm_empty, count, overflow, underflow
  );
endinterface

// File: rtl/ase_cfg_fifo.sv
// Synchronous FIFO with standard/FWFT read, occupancy count, almost flags and flush.
// Define ASE_FIFO_STICKY_ERR_EN to hold overflow/underflow until rst or flush.
module ase_cfg_fifo #(
  parameter int DATA_WIDTH      = 64,
  parameter int DEPTH_BASE2     = 3,
  parameter int ALMFULL_THRESH  = 5,
  parameter int ALMEMPTY_THRESH = 1,
  parameter int FWFT            = 0
) (
  input logic          clk,
  input logic          rst,
  ase_cfg_fifo_if.slave io
);
  localparam int DEPTH = 2 ** DEPTH_BASE2;
  localparam int CW    = DEPTH_BASE2 + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_T    = CW'(ALMFULL_THRESH);
  localparam logic [CW-1:0] AE_T    = CW'(ALMEMPTY_THRESH);

  logic [DATA_WIDTH-1:0]  mem [DEPTH];
  logic [DEPTH_BASE2-1:0] wr_addr, rd_addr;
  logic [CW-1:0]          count_q, count_next;
  logic                   full_q, empty_q, alm_full_q, alm_empty_q;
  logic                   overflow_q, underflow_q;
  logic                   wr_ok, rd_ok;

  // Flags are registered, so accept decisions see last edge's full/empty.
  assign wr_ok = io.wr_en & ~full_q  & ~io.flush;
  assign rd_ok = io.rd_en & ~empty_q & ~io.flush;

  always_comb begin
    count_next = count_q;
    if (io.flush)
      count_next = '0;
    else if (wr_ok && !rd_ok)
      count_next = count_q + 1'b1;
    else if (!wr_ok && rd_ok)
      count_next = count_q - 1'b1;
  end

  // Storage is never cleared; only the pointers are.
  always_ff @(posedge clk) begin
    if (!rst && wr_ok)
      mem[wr_addr] <= io.data_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_addr     <= '0;
      rd_addr     <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      alm_full_q  <= (AF_T == '0);
      alm_empty_q <= 1'b1;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (io.flush) begin
        wr_addr <= '0;
        rd_addr <= '0;
      end else begin
        if (wr_ok) wr_addr <= wr_addr + 1'b1;
        if (rd_ok) rd_addr <= rd_addr + 1'b1;
      end
      count_q     <= count_next;
      full_q      <= (count_next == DEPTH_C);
      empty_q     <= (count_next == '0);
      alm_full_q  <= (count_next >= AF_T);
      alm_empty_q <= (count_next <= AE_T);
      if (io.flush) begin
        overflow_q  <= 1'b0;
        underflow_q <= 1'b0;
      end else begin
`ifdef ASE_FIFO_STICKY_ERR_EN
        overflow_q  <= overflow_q  | (io.wr_en & full_q);
        underflow_q <= underflow_q | (io.rd_en & empty_q);
`else
        overflow_q  <= io.wr_en & full_q;
        underflow_q <= io.rd_en & empty_q;
`endif
      end
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head entry is presented directly; rd_en acts as pop-acknowledge.
      assign io.data_out   = mem[rd_addr];
      assign io.data_out_v = ~empty_q;
    end else begin : g_std
      logic [DATA_WIDTH-1:0] dout_q;
      logic                  dout_v_q;
      always_ff @(posedge clk) begin
        if (rst) begin
          dout_q   <= '0;
          dout_v_q <= 1'b0;
        end else begin
          dout_v_q <= rd_ok;
          if (rd_ok) dout_q <= mem[rd_addr];
        end
      end
      assign io.data_out   = dout_q;
      assign io.data_out_v = dout_v_q;
    end
  endgenerate

  assign io.full      = full_q;
  assign io.alm_full  = alm_full_q;
  assign io.empty     = empty_q;
  assign io.alm_empty = alm_empty_q;
  assign io.count     = count_q;
  assign io.overflow  = overflow_q;
  assign io.underflow = underflow_q;
endmodule
